div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle signed-divide controller for the datapath's DIV operation. It registers operands and feeds sign-magnitude operands to the combinational non-restoring `division` array. It gives the array a fixed number of settle cycles, then captures the array's 64-bit {quotient, remainder} output and applies sign correction. Corrected results go to HI (remainder) and LO (quotient) with a start/busy/done handshake. Divide-by-zero and INT_MIN corner cases are resolved here, not in the array.

## Interface
- SETTLE_CYCLES, 2, cycles allowed for the `division` array to settle; legal range ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- clr_n  in  1  reset, synchronous, active-low.
- start  in  1  request divide; sampled only in IDLE.
- dividend  in  32  signed dividend, sampled with accepted start.
- divisor  in  32  signed divisor, sampled with accepted start.
- busy  out  1  high whenever state ≠ IDLE; reset 0.
- done  out  1  one-cycle pulse; HI/LO/dbz valid from this cycle; reset 0.
- hi  out  32  signed remainder; holds until next done; reset 0.
- lo  out  32  signed quotient; holds until next done; reset 0.
- dbz  out  1  last result was divide-by-zero; updated with done; reset 0.

## Operation
- States: IDLE, SETTLE, FIX.
- IDLE, start=1:
  - Register dividend/divisor, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Register mag_a = |dividend| and mag_b = |divisor|, both 32-bit unsigned; |INT_MIN| = 32'h8000_0000.
  - If divisor==0: set special=DBZ, go to FIX.
  - Else if divisor==INT_MIN: set special=MINDIV, go to FIX.
  - Else: cnt←SETTLE_CYCLES−1, go to SETTLE.
- SETTLE:
  - `division` inputs are driven from mag_a/mag_b registers only.
  - cnt decrements each cycle.
  - At the edge where cnt==0: raw←division out, then go to FIX.
- FIX (one cycle; done←1, state←IDLE):
  - Normal case: lo = sign_q ? −raw_q : raw_q; hi = sign_r ? −raw_r : raw_r; dbz←0.
  - DBZ: lo = 32'hFFFF_FFFF, hi = dividend, dbz←1.
  - MINDIV, dividend==INT_MIN: lo=1, hi=0.
  - MINDIV, other dividend: lo=0, hi=dividend.
  - dbz←0 for MINDIV.
- Arithmetic is 32-bit two's complement with wrap. INT_MIN/−1 gives lo=32'h8000_0000, hi=0, with no flag.
- start while busy is ignored; it is not queued.
- clr_n=0 at any edge: state←IDLE, all outputs and internal registers←0, in-flight op discarded.

## Timing
- Start accepted at edge N.
- Normal path: raw captured at edge N+SETTLE_CYCLES; hi/lo/done update at edge N+SETTLE_CYCLES+1. Latency is SETTLE_CYCLES+2 cycles from start (4 for default).
- Special paths (DBZ, MINDIV): hi/lo/done update at edge N+1.
- busy rises at edge N and falls on the same edge done rises.
- A new start is accepted in the cycle done is high, so back-to-back ops issue with no gap.
- done is high for exactly one cycle per accepted start.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, SETTLE, FIX};
  - special enum {NONE, DBZ, MINDIV};
  - DIV_W=32;
  - INT_MIN=32'h8000_0000;
  - DBZ_QUOT=32'hFFFF_FFFF.
- One sub-module: existing `division`, instantiated once. It is fed mag_a/mag_b; its out[63:32]=quotient, out[31:0]=remainder.
- The settle counter is sized by $clog2(SETTLE_CYCLES+1).

## Test plan
- 17 / 5, start at cycle 0, SETTLE_CYCLES=2 → done at cycle 4, lo=3, hi=2, dbz=0; busy high cycles 1–3.
- −17 / 5 → lo=32'hFFFF_FFFD (−3), hi=32'hFFFF_FFFE (−2); 17 / −5 → lo=−3, hi=2; −17 / −5 → lo=3, hi=−2.
- 100 / 0 → done at cycle 2, lo=32'hFFFF_FFFF, hi=100, dbz=1. The next op 9 / 3 clears dbz (lo=3, hi=0).
- INT_MIN / −1 → lo=32'h8000_0000, hi=0. INT_MIN / INT_MIN → lo=1, hi=0 at cycle 2. 7 / INT_MIN → lo=0, hi=7.
- Start 20/6 at cycle 0; raise start again with 50/7 at cycle 2 (busy) → ignored; only lo=3, hi=2 at cycle 4. Start 50/7 on the done cycle → lo=7, hi=1 at cycle 8.
- Start 17/5, drive clr_n=0 at cycle 2 → from cycle 3: busy=0, done=0, hi=lo=0. done never asserts for the aborted op.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the signed-divide controller and its divider array.
// Contents:
//   state_t   - controller FSM states (IDLE, SETTLE, FIX)
//   special_t - operand corner cases resolved outside the array
//   DIV_W, INT_MIN, DBZ_QUOT - operand width and fixed result constants
//   magnitude() - absolute value as a 32-bit unsigned quantity
package div_pkg;

    localparam int DIV_W = 32;
    localparam logic [DIV_W-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [DIV_W-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FIX    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        DBZ    = 2'd1,
        MINDIV = 2'd2
    } special_t;

    // |INT_MIN| wraps back to 32'h8000_0000, which is the correct unsigned
    // magnitude when the result is read as unsigned.
    function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] x);
        return x[DIV_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/division.sv
// Combinational non-restoring unsigned divider array.
// Ports:
//   a   in  32  unsigned dividend magnitude
//   b   in  32  unsigned divisor magnitude (nonzero)
//   out out 64  {quotient[31:0], remainder[31:0]}
// Each row shifts in one dividend bit and either subtracts or adds the
// divisor depending on the sign of the previous partial remainder; the
// quotient bit is the inverted sign of the new partial remainder. A single
// add-back at the end turns a negative final remainder into the true one.
module division
    import div_pkg::*;
(
    input  logic [DIV_W-1:0]   a,
    input  logic [DIV_W-1:0]   b,
    output logic [2*DIV_W-1:0] out
);

    // Partial remainders stay within (-2b, 2b), so two guard bits suffice.
    localparam int RW = DIV_W + 2;

    logic [RW-1:0]    rem [0:DIV_W];
    logic [DIV_W-1:0] quot;
    logic [RW-1:0]    b_ext;
    logic [RW-1:0]    rem_fix;

    assign b_ext  = {2'b00, b};
    assign rem[0] = '0;

    generate
        for (genvar gi = 0; gi < DIV_W; gi++) begin : g_row
            logic [RW-1:0] shifted;
            assign shifted       = {rem[gi][RW-2:0], a[DIV_W-1-gi]};
            assign rem[gi+1]     = rem[gi][RW-1] ? (shifted + b_ext) : (shifted - b_ext);
            assign quot[DIV_W-1-gi] = ~rem[gi+1][RW-1];
        end
    endgenerate

    assign rem_fix = rem[DIV_W][RW-1] ? (rem[DIV_W] + b_ext) : rem[DIV_W];
    assign out     = {quot, rem_fix[DIV_W-1:0]};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed-divide controller.
// Registers signed operands, drives their magnitudes into the combinational
// division array, waits SETTLE_CYCLES for it to settle, captures the raw
// {quotient, remainder} and applies sign correction. Divide-by-zero and an
// INT_MIN divisor are resolved directly without using the array.
// Ports:
//   clk      in  1   clock, rising edge
//   clr_n    in  1   synchronous active-low reset
//   start    in  1   request a divide; only taken in IDLE
//   dividend in  32  signed dividend
//   divisor  in  32  signed divisor
//   busy     out 1   operation in flight
//   done     out 1   one-cycle pulse, hi/lo/dbz valid from this cycle
//   hi       out 32  signed remainder
//   lo       out 32  signed quotient
//   dbz      out 1   last result was a divide by zero
module div_ctrl
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] hi,
    output logic [DIV_W-1:0] lo,
    output logic             dbz
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t             state_reg;
    special_t           special_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DIV_W-1:0]   dividend_reg;
    logic [DIV_W-1:0]   mag_a_reg;
    logic [DIV_W-1:0]   mag_b_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic [2*DIV_W-1:0] raw_reg;
    logic [2*DIV_W-1:0] div_out;
    logic [DIV_W-1:0]   raw_q;
    logic [DIV_W-1:0]   raw_r;

    // The array only ever sees registered magnitudes, so its inputs are
    // stable for the whole settle window.
    division u_division (
        .a   (mag_a_reg),
        .b   (mag_b_reg),
        .out (div_out)
    );

    assign raw_q = raw_reg[2*DIV_W-1:DIV_W];
    assign raw_r = raw_reg[DIV_W-1:0];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_reg    <= IDLE;
            special_reg  <= NONE;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            mag_a_reg    <= '0;
            mag_b_reg    <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            raw_reg      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            dbz          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dividend_reg <= dividend;
                        mag_a_reg    <= magnitude(dividend);
                        mag_b_reg    <= magnitude(divisor);
                        sign_q_reg   <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
                        sign_r_reg   <= dividend[DIV_W-1];
                        busy         <= 1'b1;
                        if (divisor == '0) begin
                            special_reg <= DBZ;
                            state_reg   <= FIX;
                        end else if (divisor == INT_MIN) begin
                            special_reg <= MINDIV;
                            state_reg   <= FIX;
                        end else begin
                            special_reg <= NONE;
                            cnt_reg     <= CNT_W'(SETTLE_CYCLES - 1);
                            state_reg   <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_reg == '0) begin
                        raw_reg   <= div_out;
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                    case (special_reg)
                        DBZ: begin
                            lo  <= DBZ_QUOT;
                            hi  <= dividend_reg;
                            dbz <= 1'b1;
                        end
                        MINDIV: begin
                            // Only INT_MIN itself reaches a magnitude of 1
                            // against an INT_MIN divisor; all else truncates to 0.
                            if (dividend_reg == INT_MIN) begin
                                lo <= 32'd1;
                                hi <= '0;
                            end else begin
                                lo <= '0;
                                hi <= dividend_reg;
                            end
                            dbz <= 1'b0;
                        end
                        default: begin
                            lo  <= sign_q_reg ? (~raw_q + 1'b1) : raw_q;
                            hi  <= sign_r_reg ? (~raw_r + 1'b1) : raw_r;
                            dbz <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected results (with the
// cycle at which done must appear) into a queue; a negedge monitor pops and
// compares whenever done is high.
module tb_div_ctrl;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   total;
    int   bad;

    div_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .dbz      (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 lo=%h hi=%h expected no result (cycle %0d)", lo, hi, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn cycle=%0d lo=%h hi=%h dbz=%0d", cyc, lo, hi, dbz);
                check("lo", lo, e.lo);
                check("hi", hi, e.hi);
                check("dbz", {31'd0, dbz}, {31'd0, e.dbz});
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Drive one start cycle; push an expectation only when it should be taken.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edbz, input int lat, input bit take);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (take) begin
            e.lo  = elo;
            e.hi  = ehi;
            e.dbz = edbz;
            e.cyc = cyc + lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || done) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] elo, input logic [31:0] ehi,
                      input logic edbz, input int lat);
        issue(a, b, elo, ehi, edbz, lat, 1'b1);
        wait_idle();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        clr_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // 17/5 with explicit busy profile: high for cycles 1..3, low at done.
        issue(32'd17, 32'd5, 32'd3, 32'd2, 1'b0, 4, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            check("busy_inflight", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("done_rise", {31'd0, done}, 32'd1);
        wait_idle();

        // Sign correction.
        op(32'hFFFF_FFEF, 32'd5,          32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, 4);
        op(32'd17,        32'hFFFF_FFFB,  32'hFFFF_FFFD, 32'd2,         1'b0, 4);
        op(32'hFFFF_FFEF, 32'hFFFF_FFFB,  32'd3,         32'hFFFF_FFFE, 1'b0, 4);
        op(32'd5,         32'd17,         32'd0,         32'd5,         1'b0, 4);
        op(32'hFFFF_FFFF, 32'd2,          32'd0,         32'hFFFF_FFFF, 1'b0, 4);
        op(32'h7FFF_FFFF, 32'd1,          32'h7FFF_FFFF, 32'd0,         1'b0, 4);

        // Divide by zero, then a normal op clears dbz.
        op(32'd100,       32'd0,          32'hFFFF_FFFF, 32'd100,       1'b1, 2);
        op(32'd9,         32'd3,          32'd3,         32'd0,         1'b0, 4);

        // INT_MIN corners.
        op(32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 4);
        op(32'h8000_0000, 32'h8000_0000,  32'd1,         32'd0,         1'b0, 2);
        op(32'd7,         32'h8000_0000,  32'd0,         32'd7,         1'b0, 2);
        op(32'hFFFF_FFF9, 32'h8000_0000,  32'd0,         32'hFFFF_FFF9, 1'b0, 2);
        op(32'h8000_0000, 32'd7,          32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, 4);

        // Start while busy is ignored; start on the done cycle is taken.
        issue(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 4, 1'b1);
        @(posedge clk);
        #1;
        issue(32'd50, 32'd7, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        check("done_b2b", {31'd0, done}, 32'd1);
        issue(32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 4, 1'b1);
        wait_idle();

        // Abort an in-flight op with reset.
        issue(32'd17, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        clr_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done_busy", {31'd0, busy}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
